audio_key_multi: RTL and testbench

AUDIO_KEY_MULTI -- requirements
Module: audio_key_multi

---
 rtl/audio_key_pkg.sv | 35 +++
 rtl/ax_debounce.sv | 48 ++++
 rtl/audio_key_multi.sv | 198 +++++++++++++++++++
 tb/tb_audio_key_multi.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_key_pkg.sv
// Shared definitions for the multi-slot audio key recorder: FSM encoding,
// default parameters and the lowest-index key picker.
package audio_key_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RECORD = 2'd1,
      ST_PLAY   = 2'd2
   } state_t;

   localparam int DEF_NUM_SLOTS = 4;
   localparam int DEF_CNT_W     = 32;
   localparam int DB_CYCLES     = 4;
   localparam int DB_CNT_W      = 8;

   typedef struct packed {
      logic       valid;
      logic [3:0] idx;
   } pick_t;

   // Lowest set bit wins so simultaneous presses resolve deterministically.
   function automatic pick_t lowest_set(input logic [15:0] vec);
      pick_t p;
      p.valid = 1'b0;
      p.idx   = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (vec[i]) begin
            p.valid = 1'b1;
            p.idx   = 4'(i);
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/ax_debounce.sv
// Key debouncer: two-flop synchroniser, then a level change is accepted only
// after CYCLES stable samples; emits one-cycle fall (press) / rise (release).
module ax_debounce
   import audio_key_pkg::*;
#(
   parameter int CYCLES = DB_CYCLES
)
(
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic fall,
   output logic rise
);

   localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(CYCLES - 1);
   localparam logic [DB_CNT_W-1:0] CNT_ONE  = DB_CNT_W'(1);

   logic [1:0]          sync;
   logic [DB_CNT_W-1:0] cnt;
   logic                level;

   // Synchronise, then require a stable run before accepting a new level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync  <= 2'b11;
         cnt   <= {DB_CNT_W{1'b0}};
         level <= 1'b1;
         fall  <= 1'b0;
         rise  <= 1'b0;
      end else begin
         sync <= {sync[0], din};
         fall <= 1'b0;
         rise <= 1'b0;
         if (sync[1] == level) begin
            cnt <= {DB_CNT_W{1'b0}};
         end else if (cnt == CNT_LAST) begin
            cnt   <= {DB_CNT_W{1'b0}};
            level <= sync[1];
            fall  <= ~sync[1];
            rise  <= sync[1];
         end else begin
            cnt <= cnt + CNT_ONE;
         end
      end
   end

endmodule

// File: rtl/audio_key_multi.sv
// Multi-slot key recorder: a press records the hold time into that key's slot,
// release replays it. Define AUDIO_KEY_LOOP_EN for continuous looped playback.
module audio_key_multi
   import audio_key_pkg::*;
#(
   parameter int               NUM_SLOTS = DEF_NUM_SLOTS,
   parameter int               CNT_W     = DEF_CNT_W,
   parameter logic [CNT_W-1:0] MAX_LEN   = {CNT_W{1'b1}},
   localparam int              SLOT_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
)
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_SLOTS-1:0] key,
   input  logic                 play_trig,
   input  logic [SLOT_W-1:0]    play_sel,
   output logic                 record,
   output logic                 play,
   output logic [SLOT_W-1:0]    slot,
   output logic                 write_req,
   input  logic                 write_req_ack,
   output logic                 read_req,
   input  logic                 read_req_ack,
   output logic [CNT_W-1:0]     rec_len
);

   logic [NUM_SLOTS-1:0] press;
   logic [NUM_SLOTS-1:0] rel;

   for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_db
      ax_debounce u_db (
         .clk  (clk),
         .rst  (rst),
         .din  (key[i]),
         .fall (press[i]),
         .rise (rel[i])
      );
   end

   state_t            state;
   state_t            state_nx;
   logic [SLOT_W-1:0] slot_nx;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  len [NUM_SLOTS];
   logic [CNT_W:0]    cnt_inc;
   logic [CNT_W-1:0]  cnt_sat;
   pick_t             pick;
   logic              trig_ok;
   logic              rec_full;
   logic              play_done;
   logic              clr_cnt;
   logic              store_len;
   logic              start_write;
   logic              start_read;

   // Wide increment so saturation and end-of-play compares cannot wrap.
   assign cnt_inc   = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
   assign rec_full  = (cnt_inc >= {1'b0, MAX_LEN});
   assign cnt_sat   = (cnt_inc > {1'b0, MAX_LEN}) ? MAX_LEN : cnt_inc[CNT_W-1:0];
   assign play_done = (cnt_inc >= {1'b0, len[slot]});
   assign pick      = lowest_set(16'(press));
   assign trig_ok   = play_trig && (32'(play_sel) < 32'(NUM_SLOTS)) &&
                      (len[play_sel] != {CNT_W{1'b0}});
   assign rec_len   = len[slot];

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state and datapath control decisions.
   always_comb begin
      state_nx    = state;
      slot_nx     = slot;
      clr_cnt     = 1'b0;
      store_len   = 1'b0;
      start_write = 1'b0;
      start_read  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (pick.valid) begin
               state_nx    = ST_RECORD;
               slot_nx     = SLOT_W'(pick.idx);
               clr_cnt     = 1'b1;
               start_write = 1'b1;
            end else if (trig_ok) begin
               state_nx   = ST_PLAY;
               slot_nx    = play_sel;
               clr_cnt    = 1'b1;
               start_read = 1'b1;
            end else begin
               state_nx = ST_IDLE;
            end
         end
         ST_RECORD: begin
            if (rel[slot] || rec_full) begin
               store_len = 1'b1;
               clr_cnt   = 1'b1;
               if (cnt_sat != {CNT_W{1'b0}}) begin
                  state_nx   = ST_PLAY;
                  start_read = 1'b1;
               end else begin
                  state_nx = ST_IDLE;
               end
            end else begin
               state_nx = ST_RECORD;
            end
         end
         ST_PLAY: begin
            if (pick.valid) begin
               state_nx    = ST_RECORD;
               slot_nx     = SLOT_W'(pick.idx);
               clr_cnt     = 1'b1;
               start_write = 1'b1;
            end
`ifdef AUDIO_KEY_LOOP_EN
            else if (play_trig && (play_sel == slot)) begin
               state_nx = ST_IDLE;
            end else if (play_done) begin
               state_nx   = ST_PLAY;
               clr_cnt    = 1'b1;
               start_read = 1'b1;
            end
`else
            else if (play_done) begin
               state_nx = ST_IDLE;
            end
`endif
            else begin
               state_nx = ST_PLAY;
            end
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   // Output decode of the registered state.
   always_comb begin
      record = 1'b0;
      play   = 1'b0;
      case (state)
         ST_RECORD: record = 1'b1;
         ST_PLAY:   play   = 1'b1;
         default:   begin
            record = 1'b0;
            play   = 1'b0;
         end
      endcase
   end

   // Counter, slot lengths and request handshakes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot      <= {SLOT_W{1'b0}};
         cnt       <= {CNT_W{1'b0}};
         write_req <= 1'b0;
         read_req  <= 1'b0;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            len[i] <= {CNT_W{1'b0}};
         end
      end else begin
         slot <= slot_nx;
         if (clr_cnt) begin
            cnt <= {CNT_W{1'b0}};
         end else if (state == ST_RECORD) begin
            cnt <= cnt_sat;
         end else if (state == ST_PLAY) begin
            cnt <= cnt_inc[CNT_W-1:0];
         end else begin
            cnt <= cnt;
         end
         if (store_len) begin
            len[slot] <= cnt_sat;
         end
         if (start_write) begin
            write_req <= 1'b1;
         end else if (state_nx != ST_RECORD || write_req_ack) begin
            write_req <= 1'b0;
         end else begin
            write_req <= write_req;
         end
         if (start_read) begin
            read_req <= 1'b1;
         end else if (state_nx != ST_PLAY || read_req_ack) begin
            read_req <= 1'b0;
         end else begin
            read_req <= read_req;
         end
      end
   end

endmodule

// File: tb/tb_audio_key_multi.sv
// Self-checking bench for audio_key_multi: directed scenarios plus random key
// and trigger traffic compared every cycle against a behavioural slot model.
module tb_audio_key_multi;
   import audio_key_pkg::*;

   localparam int N = 4;
   localparam int D = DB_CYCLES + 3;     // raw key edge to FSM transition
   localparam longint MAXL = 64'hFFFF_FFFF;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  key;
   logic        play_trig;
   logic [1:0]  play_sel;
   logic        wack, rack;
   logic        record, play, write_req, read_req;
   logic [1:0]  slot;
   logic [31:0] rec_len;

   logic [1:0]  key_c;
   logic        trig_c = 1'b0, sel_c = 1'b0, ack_c = 1'b1;
   logic        record_c, play_c, wreq_c, rreq_c, slot_c;
   logic [7:0]  rec_len_c;

   audio_key_multi dut (
      .clk(clk), .rst(rst), .key(key), .play_trig(play_trig), .play_sel(play_sel),
      .record(record), .play(play), .slot(slot), .write_req(write_req),
      .write_req_ack(wack), .read_req(read_req), .read_req_ack(rack), .rec_len(rec_len)
   );

   audio_key_multi #(.NUM_SLOTS(2), .CNT_W(8), .MAX_LEN(8'd50)) dut_cap (
      .clk(clk), .rst(rst), .key(key_c), .play_trig(trig_c), .play_sel(sel_c),
      .record(record_c), .play(play_c), .slot(slot_c), .write_req(wreq_c),
      .write_req_ack(ack_c), .read_req(rreq_c), .read_req_ack(ack_c), .rec_len(rec_len_c)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int play_cycles = 0;

   // Reference model: mode 0 idle, 1 recording, 2 playing.
   logic [3:0] kh [0:15];
   int         m_mode, m_slot;
   longint     m_elapsed, m_left;
   longint     m_len [N];
   bit         m_wreq, m_rreq;

   task automatic start_rec(input int i);
      m_mode = 1; m_slot = i; m_elapsed = 0; m_wreq = 1'b1; m_rreq = 1'b0;
   endtask

   task automatic start_play(input int i);
      m_mode = 2; m_slot = i; m_left = m_len[i]; m_rreq = 1'b1;
   endtask

   task automatic model_edge();
      logic [3:0] p, r;
      int pk;
      p  = ~kh[D-1] & kh[D];
      r  = kh[D-1] & ~kh[D];
      pk = -1;
      for (int i = N - 1; i >= 0; i--) if (p[i]) pk = i;
      if (wack) m_wreq = 1'b0;
      if (rack) m_rreq = 1'b0;
      case (m_mode)
         0: begin
            if (pk >= 0) start_rec(pk);
            else if (play_trig && m_len[play_sel] != 0) start_play(int'(play_sel));
         end
         1: begin
            m_elapsed++;
            if (r[m_slot] || m_elapsed == MAXL) begin
               m_len[m_slot] = m_elapsed;
               m_wreq = 1'b0;
               if (m_elapsed != 0) start_play(m_slot);
               else m_mode = 0;
            end
         end
         default: begin
            if (pk >= 0) start_rec(pk);
`ifdef AUDIO_KEY_LOOP_EN
            else if (play_trig && int'(play_sel) == m_slot) begin
               m_mode = 0; m_rreq = 1'b0;
            end else begin
               m_left--;
               if (m_left == 0) begin m_left = m_len[m_slot]; m_rreq = 1'b1; end
            end
`else
            else begin
               m_left--;
               if (m_left == 0) begin m_mode = 0; m_rreq = 1'b0; end
            end
`endif
         end
      endcase
   endtask

   task automatic tick(input int n);
      for (int c = 0; c < n; c++) begin
         @(posedge clk);
         for (int i = 15; i > 0; i--) kh[i] = kh[i-1];
         kh[0] = key;
         model_edge();
         #1;
         tests++;
         if (record !== (m_mode == 1) || play !== (m_mode == 2) || slot !== 2'(m_slot) ||
             write_req !== m_wreq || read_req !== m_rreq || rec_len !== 32'(m_len[m_slot])) begin
            fails++;
            $display("FAIL model t=%0t rec/play/slot/wr/rd/len got %b/%b/%0d/%b/%b/%0d want %b/%b/%0d/%b/%b/%0d",
                     $time, record, play, slot, write_req, read_req, rec_len,
                     m_mode == 1, m_mode == 2, m_slot, m_wreq, m_rreq, m_len[m_slot]);
         end
         if (play) play_cycles++;
         play_trig = 1'b0;
         wack = ($urandom_range(0, 3) == 0);
         rack = ($urandom_range(0, 3) == 0);
      end
   endtask

   task automatic trig(input logic [1:0] sel);
      play_sel = sel; play_trig = 1'b1;
   endtask

   task automatic do_reset();
      rst = 1'b1; key = 4'hF; key_c = 2'b11; play_trig = 1'b0; play_sel = 2'd0;
      wack = 1'b0; rack = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      m_mode = 0; m_slot = 0; m_wreq = 1'b0; m_rreq = 1'b0;
      for (int i = 0; i < N; i++) m_len[i] = 0;
      for (int i = 0; i < 16; i++) kh[i] = 4'hF;
   endtask

   task automatic test_reset();
      tests++;
      if ({record, play, write_req, read_req, slot} !== 6'd0 || rec_len !== 32'd0 ||
          {record_c, play_c, wreq_c, rreq_c} !== 4'd0) begin
         fails++;
         $display("FAIL reset outputs got %b%b%b%b slot %0d len %0d want all zero",
                  record, play, write_req, read_req, slot, rec_len);
      end
   endtask

   task automatic test_max_len();
      int rc = 0, pc = 0, lp = -1;
      key_c[0] = 1'b0;
      for (int c = 0; c < 260; c++) begin
         @(posedge clk); #1;
         if (c == 199) key_c[0] = 1'b1;
         if (record_c) rc++;
         if (play_c) begin
            pc++;
            if (lp < 0) lp = int'(rec_len_c);
         end
      end
      tests++;
      if (rc != 50 || pc != 50 || lp != 50 || record_c !== 1'b0 || play_c !== 1'b0) begin
         fails++;
         $display("FAIL max_len rec=%0d play=%0d len=%0d end=%b%b want 50/50/50/00",
                  rc, pc, lp, record_c, play_c);
      end
   endtask

   task automatic test_record_play_100();
      play_cycles = 0;
      key[0] = 1'b0; tick(100);
      key[0] = 1'b1; tick(D + 120);
      tests++;
      if (play_cycles != 100 || rec_len !== 32'd100 || play !== 1'b0) begin
         fails++;
         $display("FAIL rec100 play_cycles=%0d len=%0d play=%b want 100/100/0", play_cycles, rec_len, play);
      end
   endtask

   task automatic test_simultaneous();
      play_cycles = 0;
      key[2:1] = 2'b00; tick(20);
      key[2] = 1'b1;    tick(20);
      key[1] = 1'b1;    tick(D + 50);
      tests++;
      if (slot !== 2'd1 || rec_len !== 32'd40 || play_cycles != 40) begin
         fails++;
         $display("FAIL simultaneous slot=%0d len=%0d play_cycles=%0d want 1/40/40", slot, rec_len, play_cycles);
      end
   endtask

   task automatic test_abort();
      key[0] = 1'b0; tick(30);
      key[0] = 1'b1; tick(D + 5);
      key[3] = 1'b0; tick(D);
      tests++;
      if (record !== 1'b1 || play !== 1'b0 || slot !== 2'd3) begin
         fails++;
         $display("FAIL abort rec/play/slot got %b/%b/%0d want 1/0/3", record, play, slot);
      end
      tick(5);
      key[3] = 1'b1; tick(D + 20);
      trig(2'd0); tick(3);
      tests++;
      if (play !== 1'b1 || slot !== 2'd0 || rec_len !== 32'd30) begin
         fails++;
         $display("FAIL abort_len play/slot/len got %b/%0d/%0d want 1/0/30", play, slot, rec_len);
      end
      tick(30);
   endtask

   task automatic test_play_trig();
      do_reset();
      key[0] = 1'b0; tick(30);
      key[0] = 1'b1; tick(D + 35);
      play_cycles = 0;
      trig(2'd0); tick(40);
      tests++;
      if (play_cycles != 30) begin
         fails++;
         $display("FAIL trig_play play_cycles=%0d want 30", play_cycles);
      end
      trig(2'd2); tick(5);
      tests++;
      if (play !== 1'b0 || record !== 1'b0) begin
         fails++;
         $display("FAIL trig_empty play/rec got %b/%b want 0/0", play, record);
      end
      trig(2'd0); tick(5);
      trig(2'd0); tick(30);
      key[1] = 1'b0; tick(D - 1);
      trig(2'd0); tick(1);
      tests++;
      if (record !== 1'b1 || slot !== 2'd1) begin
         fails++;
         $display("FAIL key_vs_trig rec/slot got %b/%0d want 1/1", record, slot);
      end
      tick(10);
      key[1] = 1'b1; tick(D + 20);
   endtask

   task automatic test_reset_mid();
      key[2] = 1'b0; tick(D + 20);
      #2 rst = 1'b1; #1;
      tests++;
      if ({record, play, write_req, read_req, slot} !== 6'd0 || rec_len !== 32'd0) begin
         fails++;
         $display("FAIL rst_mid_rec got %b%b%b%b slot %0d len %0d want zeros",
                  record, play, write_req, read_req, slot, rec_len);
      end
      do_reset();
      trig(2'd2); tick(5);
      key[1] = 1'b0; tick(10);
      key[1] = 1'b1; tick(D + 3);
      #2 rst = 1'b1; #1;
      tests++;
      if (play !== 1'b0 || read_req !== 1'b0 || rec_len !== 32'd0) begin
         fails++;
         $display("FAIL rst_mid_play play/rd/len got %b/%b/%0d want 0/0/0", play, read_req, rec_len);
      end
      do_reset();
   endtask

   task automatic test_random();
      for (int it = 0; it < 60; it++) begin
         int k;
         k = $urandom_range(0, N - 1);
         case ($urandom_range(0, 3))
            0: key[k] = 1'b0;
            1: key[k] = 1'b1;
            2: trig(2'($urandom_range(0, 3)));
            default: ;
         endcase
         tick($urandom_range(10, 60));
      end
      key = 4'hF;
      tick(D + 10);
   endtask

`ifdef AUDIO_KEY_LOOP_EN
   task automatic test_loop();
      do_reset();
      key[0] = 1'b0; tick(20);
      key[0] = 1'b1; tick(D + 70);
      trig(2'd0); tick(3);
      tests++;
      if (play !== 1'b0 || record !== 1'b0) begin
         fails++;
         $display("FAIL loop_stop play/rec got %b/%b want 0/0", play, record);
      end
   endtask
`endif

   initial begin
      #1_000_000;
      $display("FAIL timeout simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      do_reset();
      test_reset();
      test_max_len();
      test_record_play_100();
      test_simultaneous();
      test_abort();
      test_play_trig();
      test_reset_mid();
      test_random();
`ifdef AUDIO_KEY_LOOP_EN
      test_loop();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
